// File: rtl/cpu_arb_pkg.sv
// Shared definitions for the two-requester bus arbiter: FSM state encodings and default widths.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;

endpackage

// File: rtl/bus_arbiter_2to1_mux.sv
// Plain two-input data multiplexer used as the shared datapath of bus_arbiter_2to1.
module mux_2to1 #(
    parameter int DATA_WIDTH = cpu_arb_pkg::DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic                  i_sel,
    output logic [DATA_WIDTH-1:0] o_out
);

    assign o_out = i_sel ? i_b : i_a;

endmodule

// File: rtl/bus_arbiter_2to1.sv
// Burst-oriented round-robin arbiter sharing one datapath between two valid/ready requesters.
// Optional per-grant beat limit (MAX_BURST) is enabled by defining ARB_BURST_LIMIT_EN.
module bus_arbiter_2to1
    import cpu_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  last0,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic                  last1,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt1,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  sel,
    output logic                  busy
);

    if (MAX_BURST < 1) begin : g_bad_max_burst
        $error("MAX_BURST must be at least 1");
    end

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_sel;
    logic       r_last_grant;
    logic       w_out_valid;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_xfer;
    logic       w_limit;
    logic       w_new_grant;

`ifdef ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    logic [CNT_W-1:0] r_beat_cnt;

    // The xfer that brings the count up to MAX_BURST closes the grant.
    assign w_limit = (r_beat_cnt == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_new_grant) begin
            r_beat_cnt <= '0;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end
`else
    assign w_limit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_state_nxt = r_last_grant ? ST_GRANT0 : ST_GRANT1;
                end else if (req0) begin
                    w_state_nxt = ST_GRANT0;
                end else if (req1) begin
                    w_state_nxt = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                w_out_valid = req0;
                w_gnt0      = req0 & out_ready;
                if (w_gnt0 && (last0 || w_limit)) begin
                    w_state_nxt = req1 ? ST_GRANT1 : ST_IDLE;
                end
            end
            ST_GRANT1: begin
                w_out_valid = req1;
                w_gnt1      = req1 & out_ready;
                if (w_gnt1 && (last1 || w_limit)) begin
                    w_state_nxt = req0 ? ST_GRANT0 : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_xfer      = w_out_valid & out_ready;
    assign w_new_grant = (w_state_nxt != ST_IDLE) && (w_state_nxt != r_state);

    // sel and last_grant only move on entry into a grant; IDLE keeps the previous select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_new_grant) begin
                r_sel        <= (w_state_nxt == ST_GRANT1);
                r_last_grant <= (w_state_nxt == ST_GRANT1);
            end
        end
    end

    mux_2to1 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mux (
        .i_a  (data0),
        .i_b  (data1),
        .i_sel(r_sel),
        .o_out(out_data)
    );

    assign out_last  = r_sel ? last1 : last0;
    assign out_valid = w_out_valid;
    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign sel       = r_sel;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bus_arbiter_2to1.sv
// Directed-vector bench for bus_arbiter_2to1; builds with or without ARB_BURST_LIMIT_EN.
module tb_bus_arbiter_2to1;

`ifdef ARB_BURST_LIMIT_EN
    localparam int MAXB = 4;
    localparam int LONG_LIM = 4;
`else
    localparam int MAXB = 8;
    localparam int LONG_LIM = 10;
`endif

    logic        clk = 1'b0;
    logic        rst, req0, last0, req1, last1, out_ready;
    logic [15:0] data0, data1;
    logic        gnt0, gnt1, out_valid, out_last, sel, busy;
    logic [15:0] out_data;

    int n_checks = 0;
    int n_pass   = 0;

    bus_arbiter_2to1 #(.DATA_WIDTH(16), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .last0(last0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .last1(last1), .data1(data1), .gnt1(gnt1),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .sel(sel), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, r0, l0;
        logic [15:0] d0;
        logic        r1, l1;
        logic [15:0] d1;
        logic        rdy;
        logic        g0, g1, v;
        logic [15:0] d;
        logic        l, s, b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rs, r0, l0, input logic [15:0] d0,
                       input logic r1, l1, input logic [15:0] d1, input logic rdy,
                       input logic g0, g1, v, input logic [15:0] d,
                       input logic l, s, b);
        vec_t t;
        t.rst = rs; t.r0 = r0; t.l0 = l0; t.d0 = d0; t.r1 = r1; t.l1 = l1;
        t.d1 = d1; t.rdy = rdy; t.g0 = g0; t.g1 = g1; t.v = v; t.d = d;
        t.l = l; t.s = s; t.b = b;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input int step, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    endtask

    task automatic drive(input logic rs, r0, l0, input logic [15:0] d0,
                         input logic r1, l1, input logic [15:0] d1, input logic rdy);
        rst = rs; req0 = r0; last0 = l0; data0 = d0;
        req1 = r1; last1 = l1; data1 = d1; out_ready = rdy;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        repeat (2) @(posedge clk);

        // reset with both requesting, then first grant to requester 0
        add(1,1,0,16'hAAAA,1,0,16'h5555,1, 0,0,0,16'hAAAA,0,0,0);
        add(1,1,0,16'hAAAA,1,0,16'h5555,1, 0,0,0,16'hAAAA,0,0,0);
        add(0,1,0,16'hAAAA,1,0,16'h5555,1, 0,0,0,16'hAAAA,0,0,0);
        add(0,1,1,16'h1234,0,0,16'h5555,1, 1,0,1,16'h1234,1,0,1);
        // three-beat burst from requester 0
        add(0,1,0,16'h1111,0,0,16'h5555,1, 0,0,0,16'h1111,0,0,0);
        add(0,1,0,16'h1111,0,0,16'h5555,1, 1,0,1,16'h1111,0,0,1);
        add(0,1,0,16'h2222,0,0,16'h5555,1, 1,0,1,16'h2222,0,0,1);
        add(0,1,1,16'h3333,0,0,16'h5555,1, 1,0,1,16'h3333,1,0,1);
        add(0,0,0,16'h0000,0,0,16'h5555,1, 0,0,0,16'h0000,0,0,0);
        // reset, then alternating 2-beat bursts with no idle bubble
        add(1,0,0,16'h0000,0,0,16'h5555,1, 0,0,0,16'h0000,0,0,0);
        add(0,1,0,16'hA0A0,1,0,16'hB0B0,1, 0,0,0,16'hA0A0,0,0,0);
        add(0,1,0,16'hA0A1,1,0,16'hB0B0,1, 1,0,1,16'hA0A1,0,0,1);
        add(0,1,1,16'hA0A2,1,0,16'hB0B0,1, 1,0,1,16'hA0A2,1,0,1);
        add(0,1,0,16'hA0A3,1,0,16'hB0B1,1, 0,1,1,16'hB0B1,0,1,1);
        add(0,1,0,16'hA0A3,1,1,16'hB0B2,1, 0,1,1,16'hB0B2,1,1,1);
        add(0,1,0,16'hA0A4,1,0,16'hB0B2,1, 1,0,1,16'hA0A4,0,0,1);
        add(0,1,1,16'hA0A5,1,0,16'hB0B2,1, 1,0,1,16'hA0A5,1,0,1);
        add(0,0,0,16'hA0A5,1,0,16'hB0B3,1, 0,1,1,16'hB0B3,0,1,1);
        add(0,0,0,16'hA0A5,1,1,16'hB0B4,1, 0,1,1,16'hB0B4,1,1,1);
        // consumer stall in GRANT1
        add(0,0,0,16'hA0A5,1,1,16'hBEEF,0, 0,0,0,16'hBEEF,1,1,0);
        for (int i = 0; i < 4; i++)
            add(0,0,0,16'hA0A5,1,1,16'hBEEF,0, 0,0,1,16'hBEEF,1,1,1);
        add(0,0,0,16'hA0A5,1,1,16'hBEEF,1, 0,1,1,16'hBEEF,1,1,1);
        // reset mid-burst in GRANT1, then simultaneous requests
        add(0,0,0,16'hA0A5,1,0,16'hC001,1, 0,0,0,16'hC001,0,1,0);
        add(0,0,0,16'hA0A5,1,0,16'hC001,1, 0,1,1,16'hC001,0,1,1);
        add(1,0,0,16'hA0A5,1,0,16'hC002,1, 0,1,1,16'hC002,0,1,1);
        add(0,1,1,16'hD00D,1,1,16'hC003,1, 0,0,0,16'hD00D,1,0,0);
        add(0,1,1,16'hD00D,1,1,16'hC003,1, 1,0,1,16'hD00D,1,0,1);
        add(0,0,0,16'hD00D,1,1,16'hC003,1, 0,1,1,16'hC003,1,1,1);
        // burst pause holds the grant against a waiting requester
        add(0,1,0,16'hE000,0,1,16'hC003,1, 0,0,0,16'hC003,1,1,0);
        add(0,0,0,16'hE001,1,0,16'hF000,1, 0,0,0,16'hE001,0,0,1);
        add(0,1,1,16'hE002,1,0,16'hF000,1, 1,0,1,16'hE002,1,0,1);
        add(0,0,0,16'hE002,1,1,16'hF001,1, 0,1,1,16'hF001,1,1,1);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].r0, vecs[i].l0, vecs[i].d0,
                  vecs[i].r1, vecs[i].l1, vecs[i].d1, vecs[i].rdy);
            #1;
            chk("gnt0",      i, 16'(gnt0),      16'(vecs[i].g0));
            chk("gnt1",      i, 16'(gnt1),      16'(vecs[i].g1));
            chk("out_valid", i, 16'(out_valid), 16'(vecs[i].v));
            chk("out_data",  i, out_data,       vecs[i].d);
            chk("out_last",  i, 16'(out_last),  16'(vecs[i].l));
            chk("sel",       i, 16'(sel),       16'(vecs[i].s));
            chk("busy",      i, 16'(busy),      16'(vecs[i].b));
        end

        // long requester-0 burst with requester 1 waiting: hand-over after LONG_LIM beats
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        for (int c = 0; c <= LONG_LIM + 1; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, (c == 10), 16'(c), 1'b1, 1'b1, 16'h7777, 1'b1);
            #1;
            chk("long_gnt0", 100 + c, 16'(gnt0), 16'((c >= 1) && (c <= LONG_LIM)));
            chk("long_gnt1", 100 + c, 16'(gnt1), 16'(c == LONG_LIM + 1));
            if (c == LONG_LIM)
                chk("long_last", 100 + c, 16'(out_last), 16'(LONG_LIM == 10));
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
